fact_sched: RTL and testbench

Round-robin scheduler that shares one factorial engine among NREQ requesters. Accepts one request at a time over a valid/ready handshake, issues the operand and a one-cycle go pulse to the engine, and waits for done/err with a timeout watchdog. Returns the result to the granted requester as a one-cycle response strobe. Sits between the bus-side requester ports and the factorial core, in place of direct memory-mapped go/done polling.

---
 rtl/fact_sched.sv | 176 +++++++++++++++++
 tb/tb_fact_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_sched.sv
// fact_sched
//   Shares a single factorial engine among NREQ requesters. Requests are
//   granted round-robin. The granted operand goes to the engine with a
//   one-cycle go pulse. The scheduler then waits for done/err and returns
//   the result to the owner as a one-cycle strobe. A watchdog forces an
//   error completion if the engine stays silent for TIMEOUT cycles.
//
// Ports
//   clk        rising-edge system clock
//   rst        asynchronous, active-low reset
//   req_valid  per-requester request pending
//   req_n      per-requester 4-bit operand, requester i on [4i+3:4i]
//   req_ready  one-hot accept, combinational, only asserted in IDLE
//   rsp_valid  one-hot, one-cycle response strobe to the owner
//   rsp_nf     result, held until the next response
//   rsp_err    engine error or timeout, held with rsp_nf
//   rsp_tout   completion forced by the watchdog, held with rsp_nf
//   eng_n      operand to the engine, stable from GO through RESP
//   eng_go     one-cycle engine start pulse
//   eng_done   engine completion, result on eng_nf
//   eng_err    engine error completion
//   eng_nf     engine result
//   busy       high in every state except IDLE
//   owner      index of the current/last granted requester
module fact_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_n,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_nf,
  output logic              rsp_err,
  output logic              rsp_tout,
  output logic [3:0]        eng_n,
  output logic              eng_go,
  input  logic              eng_done,
  input  logic              eng_err,
  input  logic [31:0]       eng_nf,
  output logic              busy,
  output logic [IW-1:0]     owner
);

  // Wide enough to hold TIMEOUT-1, the last value the watchdog reaches.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GO,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   idx;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            timed_out;

  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  // Round-robin search: the first pending requester at or above the
  // pointer, wrapping around. The modulo keeps non-power-of-two NREQ legal.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // The accept is the only output that is not decoded from registers.
  // It has to be combinational so that a withdrawn request is never granted.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded outputs. Engine completions are
  // only considered in WAIT, so a stray done/err in IDLE or GO has no effect.
  always_comb begin
    state_next = state;
    eng_go     = 1'b0;
    busy       = 1'b1;
    rsp_valid  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (found) begin
          state_next = GO;
        end
      end
      GO: begin
        eng_go     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (eng_done || eng_err || timed_out) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: grant capture, watchdog and response registers.
  // An engine error has priority over done, and the result is zeroed on error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      owner    <= '0;
      eng_n    <= '0;
      cnt      <= '0;
      rsp_nf   <= '0;
      rsp_err  <= 1'b0;
      rsp_tout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            eng_n <= req_n[{grant, 2'b00} +: 4];
            owner <= grant;
            ptr   <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        GO: begin
          cnt <= '0;
        end
        WAIT: begin
          if (eng_done || eng_err) begin
            rsp_nf   <= eng_err ? 32'd0 : eng_nf;
            rsp_err  <= eng_err;
            rsp_tout <= 1'b0;
          end else if (timed_out) begin
            rsp_nf   <= 32'd0;
            rsp_err  <= 1'b1;
            rsp_tout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_sched.sv
// tb_fact_sched
//   Self-checking bench for fact_sched with NREQ=4 and TIMEOUT=16.
//   A behavioural engine model answers each go pulse. Operands above 12
//   overflow 32 bits, so the model reports an error for them. Expected grants
//   and results come from hand-derived vectors, and then from a round-robin
//   and factorial reference for randomized traffic.
module tb_fact_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int M_NORM   = 0;
  localparam int M_BOTH   = 1;
  localparam int M_SILENT = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_n;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_nf;
  logic        rsp_err;
  logic        rsp_tout;
  logic [3:0]  eng_n;
  logic        eng_go;
  logic        eng_done;
  logic        eng_err;
  logic [31:0] eng_nf;
  logic        busy;
  logic [1:0]  owner;

  int tests;
  int fails;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] nvec;
    int          mode;
    int          delay;
    bit          stray;
    int          grant;
    logic [31:0] nf;
    logic        err;
    logic        tout;
  } vec_t;

  vec_t tbl[9];

  fact_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_n(req_n),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_nf(rsp_nf),
    .rsp_err(rsp_err),
    .rsp_tout(rsp_tout),
    .eng_n(eng_n),
    .eng_go(eng_go),
    .eng_done(eng_done),
    .eng_err(eng_err),
    .eng_nf(eng_nf),
    .busy(busy),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((mask >> ((p + k) % NREQ)) & 4'b1) != 4'b0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyReset();
    rst       = 1'b0;
    req_valid = '0;
    req_n     = '0;
    eng_done  = 1'b0;
    eng_err   = 1'b0;
    eng_nf    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs one transaction. It is entered and left at the falling edge of an
  // IDLE cycle. Cycle numbers count from the accept edge.
  task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] nvec,
                               input int mode, input int delay, input bit stray,
                               input int exp_grant, input logic [31:0] exp_nf,
                               input logic exp_err, input logic exp_tout);
    int          exp_c;
    logic [3:0]  onehot;
    logic [15:0] shifted;
    logic [3:0]  exp_op;
    logic [3:0]  eng_op;
    onehot  = 4'b1 << exp_grant;
    shifted = nvec >> (4 * exp_grant);
    exp_op  = shifted[3:0];
    eng_op  = '0;
    exp_c   = (mode == M_SILENT) ? 2 + TIMEOUT : 3 + delay;
    req_valid = mask;
    req_n     = nvec;
    eng_done  = 1'b0;
    eng_err   = 1'b0;
    #1;
    checkOutput("req_ready", 32'(req_ready), 32'(onehot));
    checkOutput("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    for (int c = 1; c <= exp_c; c++) begin
      @(negedge clk);
      checkOutput("eng_go", 32'(eng_go), (c == 1) ? 32'd1 : 32'd0);
      if (c == 1) begin
        checkOutput("eng_n", 32'(eng_n), 32'(exp_op));
        eng_op = eng_n;
      end
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("req_ready_holdoff", 32'(req_ready), 32'd0);
      checkOutput("rsp_valid", 32'(rsp_valid), (c == exp_c) ? 32'(onehot) : 32'd0);
      if (c == exp_c) begin
        checkOutput("rsp_nf", rsp_nf, exp_nf);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        checkOutput("rsp_tout", 32'(rsp_tout), 32'(exp_tout));
        checkOutput("owner", 32'(owner), 32'(exp_grant));
      end
      eng_done = 1'b0;
      eng_err  = 1'b0;
      eng_nf   = $urandom;
      if (c == 1 && stray) eng_done = 1'b1;
      if (mode != M_SILENT && c == 2 + delay) begin
        if (mode == M_BOTH) begin
          eng_done = 1'b1;
          eng_err  = 1'b1;
        end else if (eng_op > 4'd12) begin
          eng_err = 1'b1;
        end else begin
          eng_done = 1'b1;
          eng_nf   = fact(eng_op);
        end
      end
      if (mode == M_SILENT && c == exp_c && stray) eng_done = 1'b1;
    end
    @(negedge clk);
    eng_done = 1'b0;
    eng_err  = 1'b0;
    checkOutput("rsp_strobe_end", 32'(rsp_valid), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int          mptr;
    int          g;
    int          mode;
    int          m;
    logic [3:0]  mask;
    logic [15:0] nvec;
    logic [15:0] sh;
    logic [3:0]  op;
    logic [31:0] enf;
    logic        eerr;
    logic        etout;
    int          seen[4];

    tests = 0;
    fails = 0;

    tbl[0] = '{4'b0001, 16'h0005, M_NORM,   6, 1'b0, 0, 32'd120,     1'b0, 1'b0};
    tbl[1] = '{4'b0100, 16'h0D00, M_NORM,   3, 1'b1, 2, 32'd0,       1'b1, 1'b0};
    tbl[2] = '{4'b1111, 16'h4321, M_NORM,   0, 1'b0, 3, 32'd24,      1'b0, 1'b0};
    tbl[3] = '{4'b1111, 16'h4321, M_NORM,   4, 1'b1, 0, 32'd1,       1'b0, 1'b0};
    tbl[4] = '{4'b1010, 16'h0070, M_NORM,   2, 1'b0, 1, 32'd5040,    1'b0, 1'b0};
    tbl[5] = '{4'b1010, 16'h0070, M_NORM,   1, 1'b0, 3, 32'd1,       1'b0, 1'b0};
    tbl[6] = '{4'b0010, 16'h00C0, M_BOTH,   1, 1'b0, 1, 32'd0,       1'b1, 1'b0};
    tbl[7] = '{4'b0001, 16'h0004, M_SILENT, 0, 1'b1, 0, 32'd0,       1'b1, 1'b1};
    tbl[8] = '{4'b1000, 16'hA000, M_NORM,   5, 1'b0, 3, 32'd3628800, 1'b0, 1'b0};

    // Reset values while reset is held.
    rst       = 1'b0;
    req_valid = '0;
    req_n     = '0;
    eng_done  = 1'b0;
    eng_err   = 1'b0;
    eng_nf    = '0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_eng_go", 32'(eng_go), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_nf", rsp_nf, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_rsp_tout", 32'(rsp_tout), 32'd0);
    checkOutput("reset_owner", 32'(owner), 32'd0);
    checkOutput("reset_eng_n", 32'(eng_n), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].mask, tbl[i].nvec, tbl[i].mode, tbl[i].delay, tbl[i].stray,
                    tbl[i].grant, tbl[i].nf, tbl[i].err, tbl[i].tout);
    end

    // Reset during WAIT: everything clears at once, and no response follows.
    req_valid = 4'b0100;
    req_n     = 16'h0600;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_wait_busy", 32'(busy), 32'd0);
    checkOutput("rst_wait_eng_go", 32'(eng_go), 32'd0);
    checkOutput("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_wait_rsp_nf", rsp_nf, 32'd0);
    checkOutput("rst_wait_owner", 32'(owner), 32'd0);
    @(negedge clk);
    eng_done = 1'b1;
    eng_nf   = 32'd99;
    @(negedge clk);
    rst      = 1'b1;
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_eng_go", 32'(eng_go), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(4'b1001, 16'h9003, M_NORM, 2, 1'b0, 0, 32'd6, 1'b0, 1'b0);

    // A stray done in IDLE must not produce a response or disturb the result.
    req_valid = '0;
    eng_done  = 1'b1;
    eng_nf    = 32'd77;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("idle_done_busy", 32'(busy), 32'd0);
      checkOutput("idle_done_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("idle_done_rsp_nf", rsp_nf, 32'd6);
    end
    eng_done = 1'b0;

    // A request withdrawn before the edge must not be granted.
    req_valid = 4'b0100;
    req_n     = 16'h0300;
    #1 checkOutput("withdraw_ready_before", 32'(req_ready), 32'h4);
    #2 req_valid = '0;
    #1 checkOutput("withdraw_ready_after", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("withdraw_busy", 32'(busy), 32'd0);
    checkOutput("withdraw_eng_go", 32'(eng_go), 32'd0);

    // The pointer must still be 1, and a done during GO must be ignored.
    applyStimulus(4'b1111, 16'h0050, M_NORM, 3, 1'b1, 1, 32'd120, 1'b0, 1'b0);

    // Fairness with all four requesting continuously from reset.
    applyReset();
    @(negedge clk);
    foreach (seen[j]) seen[j] = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1111, 16'h4321, M_NORM, i % 3, 1'b0, i % 4,
                    fact(4'(i % 4 + 1)), 1'b0, 1'b0);
      seen[i % 4]++;
    end

    // Randomized traffic against the round-robin and factorial reference.
    applyReset();
    @(negedge clk);
    mptr = 0;
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(1, 15));
      nvec = 16'($urandom);
      m    = int'($urandom_range(0, 9));
      mode = (m == 0) ? M_SILENT : (m == 1) ? M_BOTH : M_NORM;
      g    = rr_pick(mask, mptr);
      sh   = nvec >> (4 * g);
      op   = sh[3:0];
      if (mode == M_SILENT) begin
        enf = 32'd0; eerr = 1'b1; etout = 1'b1;
      end else if (mode == M_BOTH || op > 4'd12) begin
        enf = 32'd0; eerr = 1'b1; etout = 1'b0;
      end else begin
        enf = fact(op); eerr = 1'b0; etout = 1'b0;
      end
      applyStimulus(mask, nvec, mode, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    g, enf, eerr, etout);
      mptr = (g + 1) % NREQ;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
